pipeline_hazard_controller: RTL and testbench

Sequences the F/D/E/W integer pipeline. Each cycle it generates the stall and flush controls for every stage, plus the operand-forwarding selects for the Execute stage. It tracks three conditions with a small FSM: load-use hazards resolved through the load stall buffer, data-memory wait states, and control-flow redirects. It also keeps a saturating stall-cycle counter and a memory-timeout error flag for debug.

---
 rtl/pipeline_hazard_controller.sv | 171 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall, flush and operand-forwarding control for the F/D/E/W integer pipeline.
// Tracks load-use, data-memory wait and redirect conditions with a four-state FSM.
module pipeline_hazard_controller #(
   parameter int WAIT_TIMEOUT = 16,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       PCSrcE,
   input  logic             UsesA_E,
   input  logic             UsesB_E,
   input  logic [4:0]       A1_E,
   input  logic [4:0]       A2_E,
   input  logic             RegWE_E_W,
   input  logic [4:0]       A3_W,
   input  logic             MemReadW,
   input  logic [4:0]       A4_W,
   input  logic             MemAccessW,
   input  logic             MemReadyW,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallW,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      USE_BUF    = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_AT = 8'(WAIT_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [4:0]       buf_rd_q, buf_rd_d;
   logic             buf_v_q, buf_v_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             mem_wait, load_use, redirect, timeout_set;
   logic             stall_f, stall_d, stall_e, stall_w;
   logic             flush_d, flush_e, flush_w;
   logic [1:0]       fwd_a, fwd_b;

   logic [1:0]       uses_e;
   logic [1:0][4:0]  src_e;
   logic [1:0]       match_w, ld_hit, buf_hit;
   logic [1:0][1:0]  fwd_sel;

   assign uses_e   = {UsesB_E, UsesA_E};
   assign src_e    = {A2_E, A1_E};

   // Per-operand hazard detection; x0 never matches anything.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         assign match_w[gi] = uses_e[gi] & RegWE_E_W & (A3_W == src_e[gi]) & (src_e[gi] != 5'd0);
         assign ld_hit[gi]  = uses_e[gi] & MemReadW & (A4_W == src_e[gi]) & (src_e[gi] != 5'd0);
         assign buf_hit[gi] = buf_v_q & (state_q == LOAD_STALL) & uses_e[gi]
                              & (buf_rd_q == src_e[gi]) & (buf_rd_q != 5'd0);
         assign fwd_sel[gi] = buf_hit[gi] ? 2'b10 : (match_w[gi] ? 2'b01 : 2'b00);
      end
   endgenerate

   assign mem_wait = MemAccessW & ~MemReadyW;
   assign load_use = |ld_hit;
   assign redirect = (PCSrcE != 2'b00);

   always_comb begin
      state_d     = state_q;
      buf_rd_d    = buf_rd_q;
      buf_v_d     = buf_v_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_set = 1'b0;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      stall_w     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      flush_w     = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;

      if (mem_wait) begin
         // Whole pipe freezes; a pending redirect stays parked in E.
         state_d = MEM_WAIT;
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_w = 1'b1;
         if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
         timeout_set = (wait_cnt_q >= TIMEOUT_AT);
      end else begin
         wait_cnt_d = 8'd0;
         if (load_use) begin
            // Hold F/D/E and bubble W so the load result lands in the stall buffer.
            state_d  = LOAD_STALL;
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_w  = 1'b1;
            buf_rd_d = A4_W;
            buf_v_d  = 1'b1;
         end else begin
            fwd_a   = fwd_sel[0];
            fwd_b   = fwd_sel[1];
            flush_d = redirect;
            flush_e = redirect;
            case (state_q)
               LOAD_STALL: state_d = USE_BUF;
               default: begin
                  state_d = RUN;
                  buf_v_d = 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      timeout_d = timeout_q | timeout_set;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         buf_rd_q    <= 5'd0;
         buf_v_q     <= 1'b0;
         wait_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         buf_rd_q    <= buf_rd_d;
         buf_v_q     <= buf_v_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Controls are combinational on live inputs, so gate them with reset directly.
   assign StallF        = reset & stall_f;
   assign StallD        = reset & stall_d;
   assign StallE        = reset & stall_e;
   assign StallW        = reset & stall_w;
   assign FlushD        = reset & flush_d;
   assign FlushE        = reset & flush_e;
   assign FlushW        = reset & flush_w;
   assign fwdA_E        = reset ? fwd_a : 2'b00;
   assign fwdB_E        = reset ? fwd_b : 2'b00;
   assign mem_timeout_o = reset & (timeout_q | timeout_set);
   assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: each scenario task pushes the
// expected controls as it drives a cycle and pops/compares them at the falling edge.
module tb_pipeline_hazard_controller;
   localparam int CNT_W = 32;
   localparam int WT    = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       PCSrcE;
   logic             UsesA_E, UsesB_E;
   logic [4:0]       A1_E, A2_E;
   logic             RegWE_E_W;
   logic [4:0]       A3_W;
   logic             MemReadW;
   logic [4:0]       A4_W;
   logic             MemAccessW, MemReadyW;
   logic             StallF, StallD, StallE, StallW;
   logic             FlushD, FlushE, FlushW;
   logic [1:0]       fwdA_E, fwdB_E;
   logic             mem_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.WAIT_TIMEOUT(WT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .PCSrcE(PCSrcE),
      .UsesA_E(UsesA_E), .UsesB_E(UsesB_E), .A1_E(A1_E), .A2_E(A2_E),
      .RegWE_E_W(RegWE_E_W), .A3_W(A3_W), .MemReadW(MemReadW), .A4_W(A4_W),
      .MemAccessW(MemAccessW), .MemReadyW(MemReadyW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallW(StallW),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
      .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o)
   );

   typedef struct {
      logic [1:0] pc;
      logic       ua;
      logic [4:0] a1;
      logic       ub;
      logic [4:0] a2;
      logic       rwe;
      logic [4:0] a3;
      logic       mr;
      logic [4:0] a4;
      logic       ma;
      logic       mrdy;
   } stim_t;

   typedef struct {
      string            tag;
      logic [11:0]      ctl;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t             sb[$];
   int               n_cmp  = 0;
   int               n_fail = 0;
   logic [CNT_W-1:0] exp_cnt;
   logic [11:0]      obs;

   assign obs = {StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW, fwdA_E, fwdB_E, mem_timeout_o};

   function automatic stim_t S(input logic [1:0] pc, input logic ua, input logic [4:0] a1,
                               input logic ub, input logic [4:0] a2, input logic rwe,
                               input logic [4:0] a3, input logic mr, input logic [4:0] a4,
                               input logic ma, input logic mrdy);
      stim_t s;
      s.pc = pc; s.ua = ua; s.a1 = a1; s.ub = ub; s.a2 = a2; s.rwe = rwe;
      s.a3 = a3; s.mr = mr; s.a4 = a4; s.ma = ma; s.mrdy = mrdy;
      return s;
   endfunction

   // stalls {F,D,E,W}, flushes {D,E,W}, fwdA, fwdB, timeout
   function automatic logic [11:0] C(input logic [3:0] st, input logic [2:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic to);
      return {st, fl, fa, fb, to};
   endfunction

   task automatic drive(input stim_t s);
      PCSrcE = s.pc; UsesA_E = s.ua; A1_E = s.a1; UsesB_E = s.ub; A2_E = s.a2;
      RegWE_E_W = s.rwe; A3_W = s.a3; MemReadW = s.mr; A4_W = s.a4;
      MemAccessW = s.ma; MemReadyW = s.mrdy;
   endtask

   // The counter is registered: it shows stalls from earlier cycles only.
   task automatic push_exp(input string tag, input logic [11:0] ctl);
      exp_t e;
      e.tag = tag;
      e.ctl = ctl;
      e.cnt = exp_cnt;
      sb.push_back(e);
      if (ctl[11] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      sb.delete();
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1;
      #1 reset = 1'b0;
      drive(S(1, 1, 5, 1, 5, 1, 5, 1, 5, 1, 0));
      exp_cnt = '0;
      push_exp("reset_hold", C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
      #1 e = sb.pop_front();
      $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
      n_cmp++;
      if (obs !== e.ctl) begin
         n_fail++;
         $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
      end
      n_cmp++;
      if (stall_cnt_o !== e.cnt) begin
         n_fail++;
         $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
      end
      apply_reset();
      @(posedge clk); #1;
      drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push_exp("reset_idle", C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
      n_cmp++;
      if (obs !== e.ctl) begin
         n_fail++;
         $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
      end
      n_cmp++;
      if (stall_cnt_o !== e.cnt) begin
         n_fail++;
         $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
      end
   endtask

   task automatic test_alu_fwd();
      stim_t st[4];
      logic [11:0] ex[4];
      exp_t e;
      apply_reset();
      st[0] = S(0, 1, 5, 1, 6, 1, 5, 0, 0, 0, 0); ex[0] = C(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0);
      st[1] = S(0, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0); ex[1] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
      st[2] = S(0, 0, 5, 1, 5, 1, 5, 0, 0, 0, 0); ex[2] = C(4'b0000, 3'b000, 2'b00, 2'b01, 1'b0);
      st[3] = S(0, 1, 5, 1, 5, 0, 5, 0, 0, 0, 0); ex[3] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(st[i]);
         push_exp($sformatf("alu_fwd[%0d]", i), ex[i]);
         @(negedge clk);
         e = sb.pop_front();
         $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
         n_cmp++;
         if (obs !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
         end
         n_cmp++;
         if (stall_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
         end
      end
   endtask

   task automatic test_load_use();
      stim_t st[4];
      logic [11:0] ex[4];
      exp_t e;
      apply_reset();
      st[0] = S(0, 0, 0, 1, 7, 0, 0, 1, 7, 1, 1); ex[0] = C(4'b1110, 3'b001, 2'b00, 2'b00, 1'b0);
      st[1] = S(0, 1, 3, 1, 7, 1, 3, 0, 0, 0, 0); ex[1] = C(4'b0000, 3'b000, 2'b01, 2'b10, 1'b0);
      st[2] = S(0, 0, 0, 1, 7, 1, 7, 0, 0, 0, 0); ex[2] = C(4'b0000, 3'b000, 2'b00, 2'b01, 1'b0);
      st[3] = S(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0); ex[3] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(st[i]);
         push_exp($sformatf("load_use[%0d]", i), ex[i]);
         @(negedge clk);
         e = sb.pop_front();
         $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
         n_cmp++;
         if (obs !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
         end
         n_cmp++;
         if (stall_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
         end
      end
   endtask

   task automatic test_mem_wait();
      stim_t st[4];
      logic [11:0] ex[4];
      exp_t e;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         st[i] = S(0, 1, 5, 0, 0, 1, 5, 0, 0, 1, 0);
         ex[i] = C(4'b1111, 3'b000, 2'b00, 2'b00, 1'b0);
      end
      st[3] = S(0, 1, 5, 0, 0, 1, 5, 0, 0, 1, 1); ex[3] = C(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(st[i]);
         push_exp($sformatf("mem_wait[%0d]", i), ex[i]);
         @(negedge clk);
         e = sb.pop_front();
         $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
         n_cmp++;
         if (obs !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
         end
         n_cmp++;
         if (stall_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
         end
      end
   endtask

   task automatic test_timeout();
      stim_t st[8];
      logic [11:0] ex[8];
      exp_t e;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         st[i] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         ex[i] = C(4'b1111, 3'b000, 2'b00, 2'b00, (i >= WT - 1) ? 1'b1 : 1'b0);
      end
      st[5] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); ex[5] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);
      st[6] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[6] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);
      st[7] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[7] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) apply_reset();
         @(posedge clk); #1;
         drive(st[i]);
         push_exp($sformatf("timeout[%0d]", i), ex[i]);
         @(negedge clk);
         e = sb.pop_front();
         $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
         n_cmp++;
         if (obs !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
         end
         n_cmp++;
         if (stall_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
         end
      end
   endtask

   task automatic test_redirect();
      stim_t st[5];
      logic [11:0] ex[5];
      exp_t e;
      apply_reset();
      st[0] = S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[0] = C(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
      st[1] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[1] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
      st[2] = S(2, 0, 0, 1, 7, 0, 0, 1, 7, 1, 1); ex[2] = C(4'b1110, 3'b001, 2'b00, 2'b00, 1'b0);
      st[3] = S(2, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0); ex[3] = C(4'b0000, 3'b110, 2'b00, 2'b10, 1'b0);
      st[4] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[4] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         drive(st[i]);
         push_exp($sformatf("redirect[%0d]", i), ex[i]);
         @(negedge clk);
         e = sb.pop_front();
         $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
         n_cmp++;
         if (obs !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
         end
         n_cmp++;
         if (stall_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
         end
      end
   endtask

   task automatic test_coincidence();
      stim_t st[5];
      logic [11:0] ex[5];
      exp_t e;
      apply_reset();
      st[0] = S(1, 1, 9, 0, 0, 0, 0, 1, 9, 1, 0); ex[0] = C(4'b1111, 3'b000, 2'b00, 2'b00, 1'b0);
      st[1] = S(1, 1, 9, 0, 0, 0, 0, 1, 9, 1, 0); ex[1] = C(4'b1111, 3'b000, 2'b00, 2'b00, 1'b0);
      st[2] = S(1, 1, 9, 0, 0, 0, 0, 1, 9, 1, 1); ex[2] = C(4'b1110, 3'b001, 2'b00, 2'b00, 1'b0);
      st[3] = S(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0); ex[3] = C(4'b0000, 3'b110, 2'b10, 2'b00, 1'b0);
      st[4] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[4] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         drive(st[i]);
         push_exp($sformatf("coincide[%0d]", i), ex[i]);
         @(negedge clk);
         e = sb.pop_front();
         $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
         n_cmp++;
         if (obs !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
         end
         n_cmp++;
         if (stall_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[4];
      logic [11:0] ex[4];
      exp_t e;
      apply_reset();
      st[0] = S(0, 0, 0, 1, 7, 0, 0, 1, 7, 1, 1); ex[0] = C(4'b1110, 3'b001, 2'b00, 2'b00, 1'b0);
      st[1] = S(0, 1, 8, 1, 7, 0, 0, 1, 8, 1, 1); ex[1] = C(4'b1110, 3'b001, 2'b00, 2'b00, 1'b0);
      st[2] = S(0, 1, 8, 1, 7, 0, 0, 0, 0, 0, 0); ex[2] = C(4'b0000, 3'b000, 2'b10, 2'b00, 1'b0);
      st[3] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[3] = C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(st[i]);
         push_exp($sformatf("b2b[%0d]", i), ex[i]);
         @(negedge clk);
         e = sb.pop_front();
         $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
         n_cmp++;
         if (obs !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
         end
         n_cmp++;
         if (stall_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: begin
               @(posedge clk); #1;
               drive(S(0, 0, 0, 1, 7, 0, 0, 1, 7, 1, 1));
               push_exp("rst_mid[0]", C(4'b1110, 3'b001, 2'b00, 2'b00, 1'b0));
               @(negedge clk);
            end
            1: begin
               @(posedge clk); #1;
               drive(S(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0));
               push_exp("rst_mid[1]", C(4'b0000, 3'b000, 2'b00, 2'b10, 1'b0));
               #1;
            end
            2: begin
               #1 reset = 1'b0;
               exp_cnt = '0;
               push_exp("rst_mid[2]", C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
               #1;
            end
            3: begin
               drive(S(1, 1, 5, 0, 0, 1, 5, 1, 5, 1, 0));
               push_exp("rst_mid[3]", C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
               #1;
            end
            default: begin
               drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
               #1 reset = 1'b1;
               @(posedge clk); #1;
               drive(S(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0));
               push_exp("rst_mid[4]", C(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
               @(negedge clk);
            end
         endcase
         e = sb.pop_front();
         $display("txn %-16s ctl=%b cnt=%0d", e.tag, obs, stall_cnt_o);
         n_cmp++;
         if (obs !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
         end
         n_cmp++;
         if (stall_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt_o, e.cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_redirect();
      test_coincidence();
      test_back_to_back();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
